// File: rtl/parking_system.sv
// Gate controller: entrance sensor starts a 4-cycle password window, then the gate
// grants or refuses entry; LEDs blink in the result states and two 7-seg digits show the state.
module parking_system (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sensor_entrance,
  input  logic       sensor_exit,
  input  logic [1:0] password_1,
  input  logic [1:0] password_2,
  output logic       GREEN_LED,
  output logic       RED_LED,
  output logic [6:0] HEX_1,
  output logic [6:0] HEX_2
);

  typedef enum logic [2:0] {
    IDLE          = 3'd0,
    WAIT_PASSWORD = 3'd1,
    WRONG_PASS    = 3'd2,
    RIGHT_PASS    = 3'd3,
    STOP          = 3'd4
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_N     = 7'b0101011;
  localparam logic [6:0] SEG_G     = 7'b0000010;
  localparam logic [6:0] SEG_O     = 7'b1000000;
  localparam logic [6:0] SEG_S     = 7'b0010010;
  localparam logic [6:0] SEG_P     = 7'b0001100;

  state_t     state, next_state;
  logic [2:0] counter_wait;
  logic       blink;
  logic       pass_ok;

  assign pass_ok = (password_1 == 2'b01) && (password_2 == 2'b10);

  always_comb begin
    next_state = state;
    case (state)
      IDLE:          if (sensor_entrance) next_state = WAIT_PASSWORD;
      WAIT_PASSWORD: if (counter_wait == 3'd3) next_state = pass_ok ? RIGHT_PASS : WRONG_PASS;
      WRONG_PASS:    if (pass_ok) next_state = RIGHT_PASS;
      RIGHT_PASS: begin
        if (sensor_entrance && sensor_exit) next_state = STOP;
        else if (sensor_exit)               next_state = IDLE;
      end
      STOP:          if (pass_ok) next_state = RIGHT_PASS;
      default:       next_state = IDLE;
    endcase
  end

  // reset_n is active-high despite its name
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state        <= IDLE;
      counter_wait <= 3'd0;
      blink        <= 1'b0;
    end else begin
      state <= next_state;
      if (state == WAIT_PASSWORD && next_state == WAIT_PASSWORD)
        counter_wait <= (counter_wait < 3'd3) ? counter_wait + 3'd1 : 3'd3;
      else
        counter_wait <= 3'd0;
      // blink restarts at 0 on entry so the first cycle of a blinking state shows LED on
      if (next_state != state || state == IDLE || state == WAIT_PASSWORD)
        blink <= 1'b0;
      else
        blink <= ~blink;
    end
  end

  always_comb begin
    GREEN_LED = 1'b0;
    RED_LED   = 1'b0;
    HEX_1     = SEG_BLANK;
    HEX_2     = SEG_BLANK;
    case (state)
      WAIT_PASSWORD: begin RED_LED = 1'b1;     HEX_1 = SEG_E; HEX_2 = SEG_N; end
      WRONG_PASS:    begin RED_LED = ~blink;   HEX_1 = SEG_E; HEX_2 = SEG_E; end
      RIGHT_PASS:    begin GREEN_LED = ~blink; HEX_1 = SEG_G; HEX_2 = SEG_O; end
      STOP:          begin RED_LED = ~blink;   HEX_1 = SEG_S; HEX_2 = SEG_P; end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_parking_system.sv
// Scoreboard bench for parking_system: expected {GREEN,RED,HEX_1,HEX_2} queued per cycle.
module tb_parking_system;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       sensor_entrance, sensor_exit;
  logic [1:0] password_1, password_2;
  logic       GREEN_LED, RED_LED;
  logic [6:0] HEX_1, HEX_2;

  parking_system dut (
    .clk(clk), .reset_n(reset_n),
    .sensor_entrance(sensor_entrance), .sensor_exit(sensor_exit),
    .password_1(password_1), .password_2(password_2),
    .GREEN_LED(GREEN_LED), .RED_LED(RED_LED), .HEX_1(HEX_1), .HEX_2(HEX_2)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] BL = 7'h7F, E = 7'b0000110, N = 7'b0101011, G = 7'b0000010,
                         O = 7'b1000000, S = 7'b0010010, P = 7'b0001100;

  typedef struct {
    string       tag;
    logic [15:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_run  = 0;
  int   n_fail = 0;

  function automatic logic [15:0] ev(input logic g, input logic r,
                                     input logic [6:0] h1, input logic [6:0] h2);
    return {g, r, h1, h2};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got G=%b R=%b H1=%h H2=%h, want G=%b R=%b H1=%h H2=%h", tag,
               obs[15], obs[14], obs[13:7], obs[6:0], exp[15], exp[14], exp[13:7], exp[6:0]);
    end
  endtask

  task automatic pop_check();
    exp_t x;
    if (sb.size() == 0) begin
      chk("sb_empty", 16'h0, 16'h1);
    end else begin
      x = sb.pop_front();
      chk(x.tag, {GREEN_LED, RED_LED, HEX_1, HEX_2}, x.v);
    end
  endtask

  // drive inputs, queue the outputs expected after the next rising edge, then check
  task automatic cyc(input string tag, input logic se, input logic sx,
                     input logic [1:0] p1, input logic [1:0] p2, input logic [15:0] e);
    sensor_entrance = se; sensor_exit = sx; password_1 = p1; password_2 = p2;
    sb.push_back('{tag, e});
    @(posedge clk); #1;
    pop_check();
  endtask

  initial begin
    logic [15:0] idle_v, wait_v;
    idle_v = ev(0, 0, BL, BL);
    wait_v = ev(0, 1, E, N);
    reset_n = 1'b1;
    sensor_entrance = 0; sensor_exit = 0; password_1 = 0; password_2 = 0;
    #1;
    sb.push_back('{"rst_async0", idle_v});
    pop_check();
    for (int i = 0; i < 5; i++) cyc("rst_hold", 0, 0, 2'b00, 2'b00, idle_v);
    reset_n = 1'b0;
    cyc("idle", 0, 1, 2'b00, 2'b00, idle_v);

    // correct password path
    cyc("wait_ok0", 1, 0, 2'b01, 2'b10, wait_v);
    for (int i = 1; i < 4; i++) cyc("wait_ok", 0, 0, 2'b01, 2'b10, wait_v);
    cyc("right0", 0, 0, 2'b01, 2'b10, ev(1, 0, G, O));
    cyc("right1", 0, 0, 2'b01, 2'b10, ev(0, 0, G, O));
    cyc("right2", 0, 0, 2'b01, 2'b10, ev(1, 0, G, O));
    cyc("exit_idle", 0, 1, 2'b01, 2'b10, idle_v);

    // wrong password, then recovery
    cyc("wait_bad0", 1, 0, 2'b00, 2'b00, wait_v);
    for (int i = 1; i < 4; i++) cyc("wait_bad", 0, 0, 2'b00, 2'b00, wait_v);
    cyc("wrong0", 0, 0, 2'b00, 2'b00, ev(0, 1, E, E));
    cyc("wrong1", 0, 0, 2'b01, 2'b00, ev(0, 0, E, E));
    cyc("wrong2", 0, 0, 2'b00, 2'b10, ev(0, 1, E, E));
    cyc("wrong_fix", 0, 0, 2'b01, 2'b10, ev(1, 0, G, O));

    // tailgate into STOP, then release
    cyc("stop0", 1, 1, 2'b00, 2'b00, ev(0, 1, S, P));
    cyc("stop1", 0, 0, 2'b00, 2'b00, ev(0, 0, S, P));
    cyc("stop2", 1, 1, 2'b11, 2'b10, ev(0, 1, S, P));
    cyc("stop_fix", 0, 0, 2'b01, 2'b10, ev(1, 0, G, O));
    cyc("right_hold", 1, 0, 2'b00, 2'b00, ev(0, 0, G, O));
    cyc("stop_again", 1, 1, 2'b00, 2'b00, ev(0, 1, S, P));
    cyc("stop_again1", 0, 0, 2'b00, 2'b00, ev(0, 0, S, P));

    // asynchronous reset between edges
    #2;
    reset_n = 1'b1;
    #1;
    sb.push_back('{"rst_async_stop", idle_v});
    pop_check();
    cyc("rst_mid_hold", 1, 0, 2'b01, 2'b10, idle_v);
    reset_n = 1'b0;
    cyc("resume_idle", 0, 0, 2'b00, 2'b00, idle_v);
    cyc("resume_wait", 1, 0, 2'b00, 2'b00, wait_v);

    if (sb.size() != 0) chk("sb_leftover", 16'h0, 16'h1);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
